// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder slice.
//   state_e  : controller state encoding (IDLE, RUN, DONE)
//   NIBBLE_W : width of one adder step, fixed by ripple_carry_adder_4bit
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder, purely combinational.
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry into bit 0
//   Sum   : 4-bit sum
//   Cout  : carry out of bit 3
module ripple_carry_adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    always_comb begin
        logic carry;
        carry = Cin;
        Sum   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            Sum[i] = A[i] ^ B[i] ^ carry;
            carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that computes in_a + in_b + in_cin one nibble per clock
// through a single shared 4-bit ripple-carry adder, chaining the carry in a
// register between steps.
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake (in_a, in_b, in_cin)
//   out_valid / out_ready: result handshake (out_sum, out_cout)
// All outputs are registered; a result is held until out_ready is seen.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    import adder_pkg::*;

    localparam int unsigned NIB  = WIDTH / NIBBLE_W;
    localparam int unsigned IDXW = $clog2(NIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    state_e                state_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  c_q;
    logic [IDXW-1:0]       idx_q;
    logic [WIDTH-1:0]      sum_q;
    logic [WIDTH-1:0]      sum_d;
    logic                  cout_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [NIBBLE_W-1:0]   nib_a;
    logic [NIBBLE_W-1:0]   nib_b;
    logic [NIBBLE_W-1:0]   nib_sum;
    logic                  nib_cout;

    // Current nibble of each captured operand feeds the shared adder.
    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    ripple_carry_adder_4bit u_rca (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (c_q),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    // Insert the freshly computed nibble into the accumulated sum.
    always_comb begin
        sum_d = sum_q;
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        c_q        <= in_cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q <= sum_d;
                    c_q   <= nib_cout;
                    // idx stops at the last nibble rather than wrapping.
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= nib_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int total;
    int bad;
    int cyc;
    int last_hs;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vt[7];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned addition with one extra bit for the carry.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic co);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s    = full[W-1:0];
        co   = full[W];
    endtask

    // Present an operand bundle, wait for the handshake, then wait for the
    // result and compare. Operands are scrambled after capture; with junk=1
    // in_valid also stays high while the block is busy.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input string tag, input bit junk);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, " wait_ready"}, {31'd0, in_ready}, 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        tick();
        last_hs  = cyc;
        in_valid = junk;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, NIB);
        check({tag, " sum"}, {16'd0, out_sum}, {16'd0, es});
        check({tag, " cout"}, {31'd0, out_cout}, {31'd0, ec});
    endtask

    initial begin
        logic [W-1:0] es;
        logic         ec;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           prev_hs;
        int           seen_valid;
        int           seen_notready;

        total = 0;
        bad   = 0;
        cyc   = 0;
        last_hs = 0;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vt[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vt[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[6] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_sum", {16'd0, out_sum}, 32'd0);
        check("reset out_cout", {31'd0, out_cout}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout,
                  $sformatf("vec%0d", i), 1'b0);
        end

        // Reset while the third nibble is being processed
        tick();
        tick();
        in_a     = 16'h1111;
        in_b     = 16'h1111;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!in_ready && n < 100) begin
                tick();
                n++;
            end
            check("midrst wait_ready", {31'd0, in_ready}, 32'd1);
        end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_sum", {16'd0, out_sum}, 32'd0);
        check("midrst out_cout", {31'd0, out_cout}, 32'd0);
        tick();
        rst = 1'b0;
        seen_valid    = 0;
        seen_notready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen_valid++;
            if (!in_ready) seen_notready++;
        end
        check("midrst ghost_valid", seen_valid, 0);
        check("midrst ready_drop", seen_notready, 0);

        // Back-pressure with ignored operands presented while busy
        out_ready = 1'b0;
        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "bp", 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            tick();
            check($sformatf("bp%0d valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d sum", i), {16'd0, out_sum}, 32'h1000);
            check($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release valid", {31'd0, out_valid}, 32'd0);
        check("bp release ready", {31'd0, in_ready}, 32'd1);
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        model(ra, rb, rc, es, ec);
        issue(ra, rb, rc, es, ec, "bp next", 1'b0);

        // Back-to-back random operations, consumer always ready
        out_ready = 1'b1;
        prev_hs   = 0;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, ec);
            issue(ra, rb, rc, es, ec, $sformatf("b2b%0d", i), 1'b0);
            if (i > 0) check($sformatf("b2b%0d interval", i), last_hs - prev_hs, NIB + 2);
            prev_hs = last_hs;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
